line_fifo: RTL and testbench

- Single-clock, parametrised FIFO. It buffers decoded pixel/bit data between the SPI-side capture logic and the frame writer, all in the CLK_40 domain.
- Successor to the earlier pointer-compare FIFO:
  - uses all DEPTH entries, via an extra pointer wrap bit;
  - exposes an occupancy count and programmable almost-full/almost-empty flags;
  - supports first-word-fall-through or registered-read mode;
  - provides a synchronous flush and sticky overflow/underflow error flags.

---
 rtl/bad_apple_pkg.sv | 19 +
 rtl/fifo_mem_2p.sv | 40 ++++
 rtl/line_fifo.sv | 143 ++++++++++++++
 tb/tb_line_fifo.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/bad_apple_pkg.sv
// Shared definitions for the bad_apple capture path.
//   FIFO_DEFAULT_DEPTH : default FIFO entry count
//   cnt_w()            : pointer / occupancy width for a given depth
//   fifo_mode_t        : read mode selector, used to drive a FIFO's FWFT parameter
package bad_apple_pkg;

   localparam int FIFO_DEFAULT_DEPTH = 128;

   // One extra bit over the index width so 0..depth is representable.
   function automatic int cnt_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

   typedef enum logic {
      FIFO_REG_READ = 1'b0,
      FIFO_FWFT     = 1'b1
   } fifo_mode_t;

endpackage

// File: rtl/fifo_mem_2p.sv
// Simple dual-port register array: one write port, one read port.
//   clk   : write clock (and read clock when REG_RD=1)
//   we    : write enable; waddr/wdata written on the rising edge
//   re    : read enable (REG_RD=1 only); loads rdata from raddr
//   raddr : read address
//   rdata : REG_RD=0 -> mem[raddr] combinationally; REG_RD=1 -> registered
// Storage is not reset so FWFT=0 configurations can map to block RAM.
module fifo_mem_2p #(
   parameter int DWIDTH = 8,
   parameter int DEPTH  = 128,
   parameter int REG_RD = 1
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [DWIDTH-1:0]        wdata,
   input  logic                     re,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [DWIDTH-1:0]        rdata
);

   logic [DWIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem_q[waddr] <= wdata;
   end

   if (REG_RD != 0) begin : g_reg_rd
      logic [DWIDTH-1:0] rdata_q;
      always_ff @(posedge clk) begin
         if (re) rdata_q <= mem_q[raddr];
      end
      assign rdata = rdata_q;
   end else begin : g_comb_rd
      logic unused_re;
      assign unused_re = re;
      assign rdata     = mem_q[raddr];
   end

endmodule

// File: rtl/line_fifo.sv
// Single-clock FIFO between SPI capture and the frame writer (CLK_40 domain).
//   CLK_40, reset_n : clock, async active-low reset
//   clr             : synchronous flush; empties FIFO, clears sticky errors
//   wr_en/din       : push (dropped when full)
//   rd_en           : pop (ignored when empty); in FWFT mode acknowledges dout
//   dout/dout_valid : read data; registered (1-cycle) or fall-through per FWFT
//   count           : occupancy 0..DEPTH
//   empty/full/almost_empty/almost_full : status from registered pointers
//   overflow/underflow : sticky push-while-full / pop-while-empty
module line_fifo
   import bad_apple_pkg::*;
#(
   parameter int DWIDTH    = 8,
   parameter int DEPTH     = FIFO_DEFAULT_DEPTH,
   parameter int AF_THRESH = DEPTH - 4,
   parameter int AE_THRESH = 4,
   parameter int FWFT      = int'(FIFO_REG_READ)
) (
   input  logic                      CLK_40,
   input  logic                      reset_n,
   input  logic                      clr,
   input  logic                      wr_en,
   input  logic [DWIDTH-1:0]         din,
   input  logic                      rd_en,
   output logic [DWIDTH-1:0]         dout,
   output logic                      dout_valid,
   output logic [cnt_w(DEPTH)-1:0]   count,
   output logic                      empty,
   output logic                      full,
   output logic                      almost_empty,
   output logic                      almost_full,
   output logic                      overflow,
   output logic                      underflow
);

   localparam int PTR_W = cnt_w(DEPTH);
   localparam int AW    = PTR_W - 1;
   localparam logic [PTR_W-1:0] AF_L = PTR_W'(AF_THRESH);
   localparam logic [PTR_W-1:0] AE_L = PTR_W'(AE_THRESH);

   if ((DEPTH & (DEPTH - 1)) != 0 || DEPTH < 4) begin : g_bad_depth
      $error("line_fifo: DEPTH must be a power of 2 and >= 4");
   end
   if (!(AE_THRESH < AF_THRESH && AF_THRESH <= DEPTH)) begin : g_bad_thresh
      $error("line_fifo: need AE_THRESH < AF_THRESH <= DEPTH");
   end

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic             ovf_q, ovf_d, unf_q, unf_d;
   logic             push, pop;
   logic [DWIDTH-1:0] rdata;

   // MSB is the wrap bit: equal pointers = empty, same index with
   // opposite wrap = full, so all DEPTH entries are usable.
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                  (wr_ptr_q[AW] != rd_ptr_q[AW]);
   // Modular difference is exact because occupancy never exceeds DEPTH.
   assign count        = wr_ptr_q - rd_ptr_q;
   assign almost_full  = (count >= AF_L);
   assign almost_empty = (count <= AE_L);
   assign overflow     = ovf_q;
   assign underflow    = unf_q;

   assign push = wr_en && !full  && !clr;
   assign pop  = rd_en && !empty && !clr;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      ovf_d    = ovf_q;
      unf_d    = unf_q;
      if (clr) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         ovf_d    = 1'b0;
         unf_d    = 1'b0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         if (wr_en && full)  ovf_d = 1'b1;
         if (rd_en && empty) unf_d = 1'b1;
      end
   end

   always_ff @(posedge CLK_40 or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         ovf_q    <= ovf_d;
         unf_q    <= unf_d;
      end
   end

   fifo_mem_2p #(
      .DWIDTH (DWIDTH),
      .DEPTH  (DEPTH),
      .REG_RD ((FWFT == 0) ? 1 : 0)
   ) u_mem (
      .clk   (CLK_40),
      .we    (push),
      .waddr (wr_ptr_q[AW-1:0]),
      .wdata (din),
      .re    (pop),
      .raddr (rd_ptr_q[AW-1:0]),
      .rdata (rdata)
   );

   if (FWFT == 0) begin : g_reg_read
      // The RAM output register has no reset; rd_seen masks it to zero
      // until the first pop after reset so dout still resets to 0.
      logic dv_q, dv_d, rd_seen_q, rd_seen_d;

      always_comb begin
         dv_d      = pop;
         rd_seen_d = rd_seen_q | pop;
      end

      always_ff @(posedge CLK_40 or negedge reset_n) begin
         if (!reset_n) begin
            dv_q      <= 1'b0;
            rd_seen_q <= 1'b0;
         end else begin
            dv_q      <= dv_d;
            rd_seen_q <= rd_seen_d;
         end
      end

      assign dout       = rd_seen_q ? rdata : '0;
      assign dout_valid = dv_q;
   end else begin : g_fwft
      // Head word falls through; forced to zero while empty so stale
      // array contents never show on dout.
      assign dout       = empty ? '0 : rdata;
      assign dout_valid = !empty;
   end

endmodule

// File: tb/tb_line_fifo.sv
module tb_line_fifo;
   import bad_apple_pkg::*;

   logic       clk = 1'b0;
   logic       reset_n, clr, wr_en, rd_en;
   logic [7:0] din;

   logic [7:0] a_dout, b_dout;
   logic       a_dv, b_dv, a_empty, b_empty, a_full, b_full;
   logic       a_ae, b_ae, a_af, b_af, a_ovf, b_ovf, a_unf, b_unf;
   logic [3:0] a_count, b_count;

   int checks = 0;
   int passed = 0;
   int failed = 0;

   always #5 clk = ~clk;

   line_fifo #(.DWIDTH(8), .DEPTH(8), .AF_THRESH(6), .AE_THRESH(2),
               .FWFT(int'(FIFO_REG_READ))) dut_a (
      .CLK_40(clk), .reset_n(reset_n), .clr(clr), .wr_en(wr_en), .din(din),
      .rd_en(rd_en), .dout(a_dout), .dout_valid(a_dv), .count(a_count),
      .empty(a_empty), .full(a_full), .almost_empty(a_ae), .almost_full(a_af),
      .overflow(a_ovf), .underflow(a_unf));

   line_fifo #(.DWIDTH(8), .DEPTH(8), .AF_THRESH(6), .AE_THRESH(2),
               .FWFT(int'(FIFO_FWFT))) dut_b (
      .CLK_40(clk), .reset_n(reset_n), .clr(clr), .wr_en(wr_en), .din(din),
      .rd_en(rd_en), .dout(b_dout), .dout_valid(b_dv), .count(b_count),
      .empty(b_empty), .full(b_full), .almost_empty(b_ae), .almost_full(b_af),
      .overflow(b_ovf), .underflow(b_unf));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset_n = 1'b0; clr = 1'b0; wr_en = 1'b0; rd_en = 1'b0; din = 8'h00;
      repeat (3) step();

      // Reset state
      chk("rst_count", a_count, 0);
      chk("rst_empty", a_empty, 1);
      chk("rst_full",  a_full, 0);
      chk("rst_ae",    a_ae, 1);
      chk("rst_af",    a_af, 0);
      chk("rst_dout",  a_dout, 0);
      chk("rst_dv",    a_dv, 0);
      chk("rst_ovf",   a_ovf, 0);
      chk("rst_unf",   a_unf, 0);
      chk("rst_b_dout", b_dout, 0);
      chk("rst_b_dv",   b_dv, 0);
      reset_n = 1'b1;
      step();

      // Fill 0x01..0x08
      for (int i = 1; i <= 8; i++) begin
         wr_en = 1'b1; din = 8'(i);
         step();
         chk("fill_count", a_count, i);
         chk("fill_af",    a_af, (i >= 6) ? 1 : 0);
         chk("fill_ae",    a_ae, (i <= 2) ? 1 : 0);
         chk("fill_full",  a_full, (i == 8) ? 1 : 0);
      end
      din = 8'hFF;
      step();
      wr_en = 1'b0;
      chk("ovf_set",   a_ovf, 1);
      chk("ovf_count", a_count, 8);

      // Drain with registered read
      for (int i = 1; i <= 8; i++) begin
         rd_en = 1'b1;
         step();
         chk("drain_dout", a_dout, i);
         chk("drain_dv",   a_dv, 1);
         chk("drain_cnt",  a_count, 8 - i);
      end
      rd_en = 1'b0;
      step();
      chk("drain_dv_low", a_dv, 0);
      chk("drain_empty",  a_empty, 1);
      rd_en = 1'b1;
      step();
      rd_en = 1'b0;
      chk("unf_set",   a_unf, 1);
      chk("unf_dout",  a_dout, 8'h08);
      chk("unf_dv",    a_dv, 0);

      // Flush clears sticky flags
      clr = 1'b1;
      step();
      clr = 1'b0;
      chk("clr1_ovf", a_ovf, 0);
      chk("clr1_unf", a_unf, 0);

      // Wrap-around: prefill 3, then 20 cycles push+pop
      for (int i = 0; i < 3; i++) begin
         wr_en = 1'b1; din = 8'(8'h10 + i);
         step();
      end
      for (int k = 0; k < 20; k++) begin
         wr_en = 1'b1; rd_en = 1'b1; din = 8'(8'h13 + k);
         step();
         chk("wrap_count", a_count, 3);
         chk("wrap_dout",  a_dout, 8'h10 + k);
         chk("wrap_dv",    a_dv, 1);
      end
      wr_en = 1'b0; rd_en = 1'b0;
      chk("wrap_ovf", a_ovf, 0);
      chk("wrap_unf", a_unf, 0);
      chk("wrap_full", a_full, 0);

      // Push+pop while empty: only push accepted
      clr = 1'b1;
      step();
      clr = 1'b0;
      wr_en = 1'b1; rd_en = 1'b1; din = 8'h55;
      step();
      chk("sim_e_count", a_count, 1);
      chk("sim_e_unf",   a_unf, 1);
      chk("sim_e_dv",    a_dv, 0);
      rd_en = 1'b0;
      for (int i = 0; i < 7; i++) begin
         din = 8'(8'h60 + i);
         step();
      end
      chk("sim_f_pre", a_full, 1);
      // Push+pop while full: only pop accepted, write dropped
      rd_en = 1'b1; din = 8'h77;
      step();
      chk("sim_f_count", a_count, 7);
      chk("sim_f_ovf",   a_ovf, 1);
      chk("sim_f_dout",  a_dout, 8'h55);
      wr_en = 1'b0;
      step();
      step();
      rd_en = 1'b0;
      chk("pre_clr_cnt",  a_count, 5);
      chk("pre_clr_dout", a_dout, 8'h61);

      // Flush with push in the same cycle: push is ignored
      clr = 1'b1; wr_en = 1'b1; din = 8'hEE;
      step();
      clr = 1'b0; wr_en = 1'b0;
      chk("clr_count", a_count, 0);
      chk("clr_empty", a_empty, 1);
      chk("clr_ovf",   a_ovf, 0);
      chk("clr_unf",   a_unf, 0);
      chk("clr_dv",    a_dv, 0);

      // First-word-fall-through
      wr_en = 1'b1; din = 8'hA5;
      step();
      wr_en = 1'b0;
      chk("fwft_dout", b_dout, 8'hA5);
      chk("fwft_dv",   b_dv, 1);
      rd_en = 1'b1;
      step();
      rd_en = 1'b0;
      chk("fwft_dv_ack", b_dv, 0);
      chk("fwft_empty",  b_empty, 1);

      // Async reset mid-burst
      wr_en = 1'b1;
      for (int i = 0; i < 3; i++) begin
         din = 8'(8'h30 + i);
         step();
      end
      chk("burst_cnt", a_count, 3);
      #2;
      reset_n = 1'b0;
      #1;
      chk("arst_count", a_count, 0);
      chk("arst_empty", a_empty, 1);
      chk("arst_dout",  a_dout, 0);
      chk("arst_b_dv",  b_dv, 0);
      wr_en = 1'b0;
      step();
      reset_n = 1'b1;
      wr_en = 1'b1; din = 8'h3C;
      step();
      wr_en = 1'b0;
      chk("post_b_dout", b_dout, 8'h3C);
      rd_en = 1'b1;
      step();
      rd_en = 1'b0;
      chk("post_a_dout", a_dout, 8'h3C);
      chk("post_a_empty", a_empty, 1);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
